// File: rtl/fma_seq_pkg.sv
// Shared encodings for the BF16 FMA program sequencer: opcodes, FSM states,
// exception-flag bit positions and the registered operand bundle.
package fma_seq_pkg;

  typedef enum logic [1:0] {
    OP_NOP      = 2'b00,
    OP_FMA_DISP = 2'b01,
    OP_FMA_ACC  = 2'b10,
    OP_HALT     = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int NUM_FLAGS      = 7;
  localparam int FLAG_ZERO      = 6;
  localparam int FLAG_UNDERFLOW = 5;
  localparam int FLAG_OVERFLOW  = 4;
  localparam int FLAG_QNAN      = 3;
  localparam int FLAG_SNAN      = 2;
  localparam int FLAG_POS_INF   = 1;
  localparam int FLAG_NEG_INF   = 0;

  // Zero is a result property, not an exception, so it never sticks.
  localparam logic [NUM_FLAGS-1:0] STICKY_MASK = ~(NUM_FLAGS'(1) << FLAG_ZERO);

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
  } fma_opnd_t;

endpackage

// File: rtl/fma_acc_bank.sv
// N_ACC x 16-bit accumulator register file: one async read port, one
// synchronous write port, asynchronous active-high reset to zero.
module fma_acc_bank
  import fma_seq_pkg::*;
#(
  parameter  int N_ACC = 4,
  localparam int ACC_W = $clog2(N_ACC)
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             we,
  input  logic [ACC_W-1:0] waddr,
  input  logic [15:0]      wdata,
  input  logic [ACC_W-1:0] raddr,
  output logic [15:0]      rdata
);

  logic [N_ACC-1:0][15:0] acc_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) acc_q <= '0;
    else if (we) acc_q[waddr] <= wdata;
  end

  assign rdata = acc_q[raddr];

endmodule

// File: rtl/fma_seq_ctrl.sv
// Program sequencer for the BF16 FMA datapath: fetch, issue, wait FMA_LAT,
// write back to an accumulator or the display register. Optional sticky
// exception flags are built when FMA_STICKY_FLAGS_EN is defined.
module fma_seq_ctrl
  import fma_seq_pkg::*;
#(
  parameter  int PROG_DEPTH = 16,
  parameter  int N_ACC      = 4,
  parameter  int FMA_LAT    = 1,
  localparam int ADDR_W     = $clog2(PROG_DEPTH),
  localparam int ACC_W      = $clog2(N_ACC),
  localparam int INSTR_W    = 51 + ACC_W
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               start,
  output logic [ADDR_W-1:0]  pc_addr,
  input  logic [INSTR_W-1:0] instr,
  output logic [15:0]        fma_a,
  output logic [15:0]        fma_b,
  output logic [15:0]        fma_c,
  output logic               fma_valid,
  input  logic [15:0]        fma_result,
  input  logic [6:0]         fma_flags,
  output logic [15:0]        disp_val,
  output logic               busy,
  output logic               done,
  output logic [6:0]         sticky_flags
);

  localparam int LAT_W = (FMA_LAT > 1) ? $clog2(FMA_LAT) : 1;

  state_t state, state_nxt;

  op_t              dec_op;
  logic [ACC_W-1:0] dec_sel;
  logic             dec_cimm;
  logic [15:0]      dec_a, dec_b, dec_c;

  assign dec_op   = op_t'(instr[INSTR_W-1 -: 2]);
  assign dec_sel  = instr[49 +: ACC_W];
  assign dec_cimm = instr[48];
  assign dec_a    = instr[47:32];
  assign dec_b    = instr[31:16];
  assign dec_c    = instr[15:0];

  fma_opnd_t        opnd;
  logic [LAT_W-1:0] lat_cnt;
  logic             wb_acc;
  logic [ACC_W-1:0] wb_sel;
  logic [15:0]      acc_rdata;

  logic issue_fma, wb_en, pc_step, pc_clr;
  logic pc_last, lat_done;

  assign pc_last  = (pc_addr == ADDR_W'(PROG_DEPTH - 1));
  assign lat_done = (lat_cnt == LAT_W'(FMA_LAT - 1));

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue_fma = 1'b0;
    wb_en     = 1'b0;
    pc_step   = 1'b0;
    pc_clr    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          pc_clr    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        case (dec_op)
          OP_NOP: begin
            pc_step = 1'b1;
            if (pc_last) state_nxt = DONE;
          end
          OP_HALT: state_nxt = DONE;
          default: begin
            issue_fma = 1'b1;
            state_nxt = WAIT;
          end
        endcase
      end
      WAIT: begin
        if (lat_done) begin
          wb_en     = 1'b1;
          pc_step   = 1'b1;
          state_nxt = pc_last ? DONE : ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are captured once at issue and held for the whole WAIT window.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      pc_addr   <= '0;
      lat_cnt   <= '0;
      fma_valid <= 1'b0;
      opnd      <= '0;
      wb_acc    <= 1'b0;
      wb_sel    <= '0;
      disp_val  <= '0;
    end else begin
      fma_valid <= issue_fma;
      if (pc_clr)       pc_addr <= '0;
      else if (pc_step) pc_addr <= pc_last ? '0 : pc_addr + ADDR_W'(1);
      if (issue_fma) begin
        opnd.a  <= dec_a;
        opnd.b  <= dec_b;
        opnd.c  <= dec_cimm ? dec_c : acc_rdata;
        wb_acc  <= (dec_op == OP_FMA_ACC);
        wb_sel  <= dec_sel;
        lat_cnt <= '0;
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt + LAT_W'(1);
      end
      if (wb_en && !wb_acc) disp_val <= fma_result;
    end
  end

  assign fma_a = opnd.a;
  assign fma_b = opnd.b;
  assign fma_c = opnd.c;
  assign busy  = (state == ISSUE) || (state == WAIT);
  assign done  = (state == DONE);

  fma_acc_bank #(.N_ACC(N_ACC)) u_acc (
    .clk_in (clk_in),
    .rst    (rst),
    .we     (wb_en && wb_acc),
    .waddr  (wb_sel),
    .wdata  (fma_result),
    .raddr  (dec_sel),
    .rdata  (acc_rdata)
  );

`ifdef FMA_STICKY_FLAGS_EN
  logic [NUM_FLAGS-1:0] sticky_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)         sticky_q <= '0;
    else if (pc_clr) sticky_q <= '0;
    else if (wb_en)  sticky_q <= sticky_q | (fma_flags & STICKY_MASK);
  end

  assign sticky_flags = sticky_q;
`else
  logic flags_unused;
  assign flags_unused = ^fma_flags;
  assign sticky_flags = '0;
`endif

endmodule

// File: tb/tb_fma_seq_ctrl.sv
// Self-checking bench for fma_seq_ctrl: instruction-cost reference model,
// per-cycle compare, directed literal checks and randomized programs.
module tb_fma_seq_ctrl;

  localparam int DEPTH = 16;
  localparam int NACC  = 4;
  localparam int LAT   = 3;
  localparam int AW    = 4;
  localparam int ACC_W = 2;
  localparam int IW    = 51 + ACC_W;

  logic          clk_in = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] pc_addr;
  logic [IW-1:0] instr;
  logic [15:0]   fma_a, fma_b, fma_c, fma_result, disp_val;
  logic          fma_valid, busy, done;
  logic [6:0]    fma_flags, sticky_flags;

  logic [IW-1:0] prog [DEPTH];
  logic [6:0]    flag_inj = '0;
  bit            rand_flags = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;

  fma_seq_ctrl #(.PROG_DEPTH(DEPTH), .N_ACC(NACC), .FMA_LAT(LAT)) dut (
    .clk_in(clk_in), .rst(rst), .start(start), .pc_addr(pc_addr), .instr(instr),
    .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c), .fma_valid(fma_valid),
    .fma_result(fma_result), .fma_flags(fma_flags), .disp_val(disp_val),
    .busy(busy), .done(done), .sticky_flags(sticky_flags)
  );

  always #5 clk_in = ~clk_in;

  assign instr = prog[pc_addr];

  // Stand-in FMA unit: exact BF16 results for the directed cases, a
  // scramble otherwise. Result/flags are only valid FMA_LAT cycles after
  // issue, so an early or late capture picks up junk.
  function automatic logic [15:0] fake_fma(input logic [15:0] a, b, c);
    if (a == 16'h4000 && b == 16'h4000 && c == 16'h3F80) return 16'h40A0;
    if (a == 16'h3F80 && b == 16'h4000 && c == 16'h0000) return 16'h4000;
    if (a == 16'h3F80 && b == 16'h4000 && c == 16'h4000) return 16'h4080;
    if (a == 16'h0000 && b == 16'h0000) return c;
    return {a[7:0] ^ c[15:8], b[15:8] + c[7:0]} ^ {b[7:0], a[15:8]};
  endfunction

  int  since = 0;
  logic res_ok;
  always @(posedge clk_in) since <= fma_valid ? 1 : (since < 1000 ? since + 1 : since);
  always_comb begin
    res_ok     = fma_valid ? (LAT == 1) : (since == LAT - 1);
    fma_result = res_ok ? fake_fma(fma_a, fma_b, fma_c) : (16'hBAD0 ^ 16'(since));
    fma_flags  = res_ok ? flag_inj : 7'h7F;
  end

  function automatic logic [IW-1:0] mk(input logic [1:0] op, input int sel, input bit cimm,
                                       input logic [15:0] a, b, c);
    logic [ACC_W-1:0] s;
    s = ACC_W'(sel);
    return {op, s, cimm, a, b, c};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each instruction has a fixed cost (NOP/HALT 1 cycle,
  // FMA LAT+1 cycles); m_left counts the cycles still owed by the current FMA.
  bit          m_running, m_done, m_valid, m_to_acc;
  int          m_pc, m_left, m_sel;
  logic [15:0] m_a, m_b, m_c, m_disp;
  logic [15:0] m_acc [NACC];
  logic [6:0]  m_sticky;

  task automatic m_advance();
    if (m_pc == DEPTH - 1) begin
      m_pc = 0; m_running = 0; m_done = 1;
    end else m_pc++;
  endtask

  task automatic model_step();
    logic [IW-1:0] w;
    logic [15:0]   r;
    int            op;
    m_valid = 0;
    if (!m_running) begin
      if (start) begin
        m_running = 1; m_done = 0; m_pc = 0; m_left = 0;
`ifdef FMA_STICKY_FLAGS_EN
        m_sticky = '0;
`endif
      end
    end else if (m_left == 0) begin
      w  = prog[m_pc];
      op = int'(w[IW-1 -: 2]);
      if (op == 0) m_advance();
      else if (op == 3) begin m_running = 0; m_done = 1; end
      else begin
        m_sel    = int'(w[49 +: ACC_W]);
        m_a      = w[47:32];
        m_b      = w[31:16];
        m_c      = w[48] ? w[15:0] : m_acc[m_sel];
        m_to_acc = (op == 2);
        m_valid  = 1;
        m_left   = LAT;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        r = fake_fma(m_a, m_b, m_c);
        if (m_to_acc) m_acc[m_sel] = r; else m_disp = r;
`ifdef FMA_STICKY_FLAGS_EN
        m_sticky = m_sticky | (flag_inj & 7'h3F);
`endif
        m_advance();
      end
    end
  endtask

  initial forever begin
    @(posedge clk_in or posedge rst);
    if (rst) begin
      m_running = 0; m_done = 0; m_valid = 0; m_pc = 0; m_left = 0;
      m_a = '0; m_b = '0; m_c = '0; m_disp = '0; m_sticky = '0;
      for (int i = 0; i < NACC; i++) m_acc[i] = '0;
    end else model_step();
  end

  initial forever begin
    @(posedge clk_in);
    #1;
    if (!rst) begin
      chk("pc_addr", 32'(pc_addr), 32'(m_pc));
      chk("busy", 32'(busy), 32'(m_running));
      chk("done", 32'(done), 32'(m_done));
      chk("fma_valid", 32'(fma_valid), 32'(m_valid));
      chk("disp_val", 32'(disp_val), 32'(m_disp));
      chk("sticky", 32'(sticky_flags), 32'(m_sticky));
      if (m_running && m_left > 0) begin
        chk("fma_a", 32'(fma_a), 32'(m_a));
        chk("fma_b", 32'(fma_b), 32'(m_b));
        chk("fma_c", 32'(fma_c), 32'(m_c));
      end
      if (fma_valid) n_valid++;
    end
  end

  // Pulse start, then count edges until done; optional stray start pulses
  // while busy and optional random flag injection.
  task automatic run_prog(input bit junk, output int cyc);
    @(negedge clk_in); start = 1'b1;
    @(posedge clk_in); #1; start = 1'b0;
    cyc = 0;
    while (1) begin
      @(negedge clk_in);
      start = junk && ($urandom_range(0, 5) == 0);
      if (rand_flags) flag_inj = 7'($urandom);
      @(posedge clk_in); #1; start = 1'b0;
      cyc++;
      if (done) break;
      if (cyc >= 200) begin
        n_checks++; n_fail++;
        $display("FAIL run_timeout: got no done after %0d cycles expected done", cyc);
        break;
      end
    end
  endtask

  task automatic fill_halt();
    for (int i = 0; i < DEPTH; i++) prog[i] = mk(2'b11, 0, 1'b0, 16'h0, 16'h0, 16'h0);
  endtask

  int cyc;

  initial begin
    fill_halt();
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_pc", 32'(pc_addr), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_disp", 32'(disp_val), 32'h0);
    chk("rst_valid", 32'(fma_valid), 32'h0);
    chk("rst_ops", {fma_a, fma_b}, 32'h0);
    chk("rst_sticky", 32'(sticky_flags), 32'h0);
    @(negedge clk_in); rst = 1'b0;
    repeat (2) @(negedge clk_in);

    // 1: single FMA_DISP then HALT
    fill_halt();
    prog[0] = mk(2'b01, 0, 1'b1, 16'h4000, 16'h4000, 16'h3F80);
    n_valid = 0;
    run_prog(1'b0, cyc);
    chk("t1_disp", 32'(disp_val), 32'h40A0);
    chk("t1_cycles", cyc, LAT + 2);
    chk("t1_nvalid", n_valid, 1);
    chk("t1_busy", 32'(busy), 32'h0);
    chk("t1_done", 32'(done), 32'h1);

    // 2: accumulator chaining through acc0
    fill_halt();
    prog[0] = mk(2'b10, 0, 1'b0, 16'h3F80, 16'h4000, 16'h0);
    prog[1] = mk(2'b10, 0, 1'b0, 16'h3F80, 16'h4000, 16'h0);
    prog[2] = mk(2'b01, 0, 1'b0, 16'h0000, 16'h0000, 16'h0);
    run_prog(1'b0, cyc);
    chk("t2_disp", 32'(disp_val), 32'h4080);
    chk("t2_cycles", cyc, 3 * (LAT + 1) + 1);

    // 3: FMA cost LAT+1, NOP cost 1
    fill_halt();
    prog[0] = mk(2'b01, 1, 1'b1, 16'h1234, 16'h5678, 16'h9ABC);
    prog[1] = mk(2'b00, 0, 1'b0, 16'h0, 16'h0, 16'h0);
    run_prog(1'b0, cyc);
    chk("t3_cycles", cyc, LAT + 3);
    fill_halt();
    prog[0] = mk(2'b00, 0, 1'b0, 16'h0, 16'h0, 16'h0);
    prog[1] = mk(2'b00, 0, 1'b0, 16'h0, 16'h0, 16'h0);
    run_prog(1'b0, cyc);
    chk("t3_nop_cycles", cyc, 3);

    // 4: all NOPs wrap to done, stray starts ignored
    for (int i = 0; i < DEPTH; i++) prog[i] = mk(2'b00, 0, 1'b0, 16'h0, 16'h0, 16'h0);
    run_prog(1'b1, cyc);
    chk("t4_cycles", cyc, DEPTH);
    chk("t4_pc", 32'(pc_addr), 32'h0);
    chk("t4_done", 32'(done), 32'h1);

    // 6: sticky flags; zero bit never accumulates, cleared on start
    fill_halt();
    prog[0] = mk(2'b01, 0, 1'b1, 16'h4000, 16'h4000, 16'h3F80);
    flag_inj = 7'h50;
    run_prog(1'b0, cyc);
    flag_inj = 7'h00;
    repeat (3) @(posedge clk_in);
    #1;
`ifdef FMA_STICKY_FLAGS_EN
    chk("t6_sticky", 32'(sticky_flags), 32'h10);
`else
    chk("t6_sticky", 32'(sticky_flags), 32'h0);
`endif
    fill_halt();
    run_prog(1'b0, cyc);
    chk("t6_sticky_clr", 32'(sticky_flags), 32'h0);

    // randomized programs
    rand_flags = 1'b1;
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        int k;
        logic [1:0] op;
        k  = $urandom_range(0, 19);
        op = (k == 0) ? 2'b11 : (k < 5) ? 2'b00 : (k < 12) ? 2'b01 : 2'b10;
        prog[i] = mk(op, $urandom_range(0, NACC - 1), 1'($urandom),
                     16'($urandom), 16'($urandom), 16'($urandom));
      end
      run_prog(1'b1, cyc);
    end
    rand_flags = 1'b0;
    flag_inj   = 7'h00;

    // 5: reset during WAIT
    fill_halt();
    prog[0] = mk(2'b01, 0, 1'b1, 16'h4000, 16'h4000, 16'h3F80);
    prog[1] = mk(2'b10, 3, 1'b1, 16'h3F80, 16'h4000, 16'h0000);
    run_prog(1'b0, cyc);
    fill_halt();
    prog[0] = mk(2'b01, 0, 1'b1, 16'h1111, 16'h2222, 16'h3333);
    @(negedge clk_in); start = 1'b1;
    @(posedge clk_in); #1; start = 1'b0;
    @(posedge clk_in); #1;
    chk("t5_pre_valid", 32'(fma_valid), 32'h1);
    @(negedge clk_in); rst = 1'b1;
    #1;
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_done", 32'(done), 32'h0);
    chk("t5_pc", 32'(pc_addr), 32'h0);
    chk("t5_disp", 32'(disp_val), 32'h0);
    chk("t5_valid", 32'(fma_valid), 32'h0);
    chk("t5_ops", {fma_a, fma_c}, 32'h0);
    @(negedge clk_in); rst = 1'b0;
    for (int i = 0; i < NACC; i++) prog[i] = mk(2'b01, i, 1'b0, 16'h0, 16'h0, 16'h0);
    run_prog(1'b0, cyc);
    chk("t5_acc3_zero", 32'(disp_val), 32'h0);
    chk("t5_cycles", cyc, NACC * (LAT + 1) + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
